// File: rtl/bus_pkg.sv
// Shared bus definitions: ID field layout, broadcast ID, fill-level status encoding.
// Used by the receive endpoint and by test-side agents and drivers.
package bus_pkg;

    localparam int ID_BITS = 8;
    localparam logic [ID_BITS-1:0] BCAST_ID = 8'hFF;
    // Widest bus word the ID helper can take.
    localparam int MAX_WORD = 64;

    typedef enum logic [1:0] {
        FILL_EMPTY,
        FILL_PARTIAL,
        FILL_FULL
    } fill_state_t;

    // Returns the top ID_BITS bits of a word that is width bits wide.
    function automatic logic [ID_BITS-1:0] get_id(input logic [MAX_WORD-1:0] word,
                                                  input int width);
        return word[width-1 -: ID_BITS];
    endfunction

endpackage

// File: rtl/bus_rx_fifo.sv
// First-word-fall-through FIFO of any depth >= 2; pointers wrap explicitly at depth-1.
// rd_data shows the head word combinationally from the registered read pointer.
module bus_rx_fifo
    import bus_pkg::*;
#(
    parameter int width = 16,
    parameter int depth = 8,
    localparam int CW = $clog2(depth + 1),
    localparam int PW = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    input  logic             rd_en,
    output logic [width-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    fill_state_t      fill_state;
    logic             do_wr, do_rd;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        fill_state = FILL_PARTIAL;
        if (count_reg == '0)
            fill_state = FILL_EMPTY;
        else if (count_reg == CW'(depth))
            fill_state = FILL_FULL;
    end

    assign empty = (fill_state == FILL_EMPTY);
    assign full  = (fill_state == FILL_FULL);

    // A write into a full FIFO is allowed only when the head leaves in the same cycle.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    always_comb begin
        wr_ptr_next = do_wr ? bump(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next = do_rd ? bump(rd_ptr_reg) : rd_ptr_reg;
        count_next  = count_reg;
        case ({do_wr, do_rd})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (do_wr && !reset)
            mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/bus_rx_endpoint.sv
// Receive endpoint for one bus port: ID filter, FWFT buffer, saturating overflow-drop counter.
// Define BUS_RX_BCAST_EN to also accept words addressed to the broadcast ID 8'hFF.
module bus_rx_endpoint
    import bus_pkg::*;
#(
    parameter int pckg_sz   = 16,
    parameter int deep_fifo = 8,
    parameter int drvrs     = 4,
    parameter int my_id     = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic [pckg_sz-1:0]               D_push,
    output logic                             rd_valid,
    output logic [pckg_sz-1:0]               rd_data,
    input  logic                             rd_ready,
    output logic                             full,
    output logic [$clog2(deep_fifo+1)-1:0]   count,
    output logic [15:0]                      drop_cnt
);

    if (pckg_sz <= ID_BITS || pckg_sz > MAX_WORD) begin : g_chk_sz
        $error("bus_rx_endpoint: pckg_sz must be in (8, 64]");
    end
    if (deep_fifo < 2) begin : g_chk_depth
        $error("bus_rx_endpoint: deep_fifo must be at least 2");
    end
    if (my_id < 0 || my_id >= drvrs || my_id > 255) begin : g_chk_id
        $error("bus_rx_endpoint: my_id must be below drvrs and fit in the ID field");
    end

    logic [ID_BITS-1:0] rx_id;
    logic               match, pop, wr_en, drop, fifo_empty;
    logic [15:0]        drop_cnt_reg, drop_cnt_next;

    assign rx_id = get_id(MAX_WORD'(D_push), pckg_sz);

`ifdef BUS_RX_BCAST_EN
    assign match = (rx_id == ID_BITS'(my_id)) | (rx_id == BCAST_ID);
`else
    assign match = (rx_id == ID_BITS'(my_id));
`endif

    assign rd_valid = ~fifo_empty;
    assign pop      = rd_valid & rd_ready;
    assign wr_en    = push & match & (~full | pop);
    assign drop     = push & match & full & ~pop;

    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (drop && drop_cnt_reg != 16'hFFFF)
            drop_cnt_next = drop_cnt_reg + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt_reg <= '0;
        else
            drop_cnt_reg <= drop_cnt_next;
    end

    assign drop_cnt = drop_cnt_reg;

    bus_rx_fifo #(
        .width (pckg_sz),
        .depth (deep_fifo)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (D_push),
        .rd_en   (pop),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_bus_rx_endpoint.sv
// Bench for bus_rx_endpoint (pckg_sz=16, deep_fifo=8, my_id=2): directed scenarios plus
// randomized traffic checked against a queue-based reference model.
module tb_bus_rx_endpoint;

    localparam int PW    = 16;
    localparam int DEPTH = 8;
    localparam int DRV   = 4;
    localparam int MYID  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic [PW-1:0] D_push = '0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [PW-1:0] rd_data;
    logic          full;
    logic [3:0]    count;
    logic [15:0]   drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] mq[$];
    int unsigned   mdrop = 0;

    always #5 clk = ~clk;

    bus_rx_endpoint #(
        .pckg_sz   (PW),
        .deep_fifo (DEPTH),
        .drvrs     (DRV),
        .my_id     (MYID)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .D_push   (D_push),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .full     (full),
        .count    (count),
        .drop_cnt (drop_cnt)
    );

    function automatic bit id_match(input logic [PW-1:0] w);
        logic [7:0] id;
        id = w[PW-1 -: 8];
`ifdef BUS_RX_BCAST_EN
        return (id == 8'(MYID)) || (id == 8'hFF);
`else
        return id == 8'(MYID);
`endif
    endfunction

    // One clock: drive inputs, advance the reference model, sample #1 after the edge.
    task automatic cycle(input logic p, input logic [PW-1:0] d, input logic r, input logic rst);
        bit was_full, pop;
        push = p; D_push = d; rd_ready = r; reset = rst;
        if (rst) begin
            mq.delete();
            mdrop = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            pop = (mq.size() != 0) && r;
            if (pop) void'(mq.pop_front());
            if (p && id_match(d)) begin
                if (!was_full || pop) mq.push_back(d);
                else if (mdrop != 32'hFFFF) mdrop++;
            end
        end
        @(posedge clk); #1;
        $display("cycle t=%0t push=%0b d=%h rdy=%0b rst=%0b -> valid=%0b data=%h cnt=%0d full=%0b drop=%0d",
                 $time, p, d, r, rst, rd_valid, rd_data, count, full, drop_cnt);
        push = 1'b0; rd_ready = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rd_valid); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_basic();
        cycle(1'b1, 16'h02A5, 1'b0, 1'b0);
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", rd_valid); end
        checks++; if (rd_data !== 16'h02A5) begin errors++; $display("FAIL basic_data got %h want 02a5", rd_data); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL basic_count got %0d want 1", count); end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid got %b want 0", rd_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL basic_pop_count got %0d want 0", count); end
    endtask

    task automatic test_filter();
        cycle(1'b1, 16'h0311, 1'b0, 1'b0);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL filter_valid got %b want 0", rd_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL filter_count got %0d want 0", count); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL filter_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
            if (i == 7) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full8 got %b want 1", full); end
            end
        end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", count); end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop got %0d want 1", drop_cnt); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 16'h0200 + 16'(i)) begin
                errors++; $display("FAIL ovf_drain%0d got v=%b %h want v=1 %h", i, rd_valid, rd_data, 16'h0200 + 16'(i));
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        checks++; if (rd_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL ovf_empty got v=%b cnt=%0d want v=0 cnt=0", rd_valid, count); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0210 + 16'(i), 1'b0, 1'b0);
        cycle(1'b1, 16'h02FF, 1'b1, 1'b0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fpp_count got %0d want 8", count); end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL fpp_drop got %0d want 1", drop_cnt); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fpp_full got %b want 1", full); end
        for (int i = 0; i < 8; i++) begin
            logic [PW-1:0] exp;
            exp = (i < 7) ? 16'h0211 + 16'(i) : 16'h02FF;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                errors++; $display("FAIL fpp_drain%0d got v=%b %h want v=1 %h", i, rd_valid, rd_data, exp);
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_bcast();
        cycle(1'b1, 16'hFF33, 1'b0, 1'b0);
`ifdef BUS_RX_BCAST_EN
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'hFF33) begin errors++; $display("FAIL bcast_accept got v=%b %h want v=1 ff33", rd_valid, rd_data); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL bcast_count got %0d want 1", count); end
        cycle(1'b0, '0, 1'b1, 1'b0);
`else
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL bcast_ignore got v=%b want 0", rd_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL bcast_count got %0d want 0", count); end
`endif
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0230 + 16'(i), 1'b0, 1'b0);
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL mid_fill got %0d want 5", count); end
        cycle(1'b1, 16'h0250, 1'b0, 1'b1);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL mid_count got %0d want 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", rd_valid); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_drop got %0d want 0", drop_cnt); end
        cycle(1'b1, 16'h0277, 1'b0, 1'b0);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h0277) begin errors++; $display("FAIL mid_after got v=%b %h want v=1 0277", rd_valid, rd_data); end
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic          p, r, rst;
            logic [PW-1:0] d;
            logic [7:0]    id;
            case ($urandom_range(0, 3))
                0, 1:    id = 8'(MYID);
                2:       id = 8'hFF;
                default: id = 8'($urandom_range(0, 255));
            endcase
            d   = {id, 8'($urandom_range(0, 255))};
            p   = ($urandom_range(0, 99) < 60);
            r   = ($urandom_range(0, 99) < 35);
            rst = ($urandom_range(0, 99) < 2);
            cycle(p, d, r, rst);
            checks++;
            if (rd_valid !== (mq.size() != 0)) begin
                errors++; $display("FAIL rnd%0d_valid got %b want %b", n, rd_valid, mq.size() != 0);
            end
            checks++;
            if (count !== 4'(mq.size()) || full !== (mq.size() == DEPTH)) begin
                errors++; $display("FAIL rnd%0d_level got cnt=%0d full=%b want cnt=%0d full=%b", n, count, full, mq.size(), mq.size() == DEPTH);
            end
            checks++;
            if (drop_cnt !== 16'(mdrop)) begin
                errors++; $display("FAIL rnd%0d_drop got %0d want %0d", n, drop_cnt, mdrop);
            end
            if (mq.size() != 0) begin
                checks++;
                if (rd_data !== mq[0]) begin
                    errors++; $display("FAIL rnd%0d_data got %h want %h", n, rd_data, mq[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_filter();
        test_overflow();
        test_full_push_pop();
        test_bcast();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
